// File: rtl/hazard_ctrl_pipe.sv
// Pipeline hazard controller: per-stage stall/clear, PC redirect, operand forwarding, predictor strobes.
// Define HAZARD_PERF_CNT_EN to add perf_cnt_o = {mispredict_cnt, miss_stall_cnt, lu_stall_cnt}.
module hazard_ctrl_pipe #(
  parameter int NUM_RS     = 2,
  parameter int FWD_STAGES = 2,
  parameter int LU_CYCLES  = 1,
  parameter bit USE_BP     = 1'b1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      jump_i,
  input  logic                                      branch_in_ex_i,
  input  logic                                      branch_taken_i,
  input  logic                                      branch_pred_i,
  input  logic [NUM_RS*5-1:0]                       rs_addr_ex_i,
  input  logic [NUM_RS-1:0]                         rs_used_ex_i,
  input  logic [FWD_STAGES*5-1:0]                   wb_addr_i,
  input  logic [FWD_STAGES-1:0]                     wb_we_i,
  input  logic                                      mem_load_i,
  input  logic                                      mem_miss_i,
  output logic                                      pc_set_o,
  output logic [3:0]                                pc_mux_o,
  output logic [4:0]                                stall_o,
  output logic [4:0]                                clear_o,
  output logic [NUM_RS*$clog2(FWD_STAGES+1)-1:0]    fwd_sel_o,
  output logic                                      btb_we_o,
  output logic                                      btb_clear_o,
  output logic                                      bht_we_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [95:0]                               perf_cnt_o
`endif
);

  localparam int SW = $clog2(FWD_STAGES + 1);
  localparam int CW = $clog2(LU_CYCLES + 1);
  localparam logic [CW-1:0] LU_INIT = CW'(LU_CYCLES - 1);

  localparam logic [3:0] PC_BOOT    = 4'd0;
  localparam logic [3:0] PC_JUMP    = 4'd1;
  localparam logic [3:0] PC_BRANCH  = 4'd2;
  localparam logic [3:0] PC_EX_INCR = 4'd3;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_LU   = 2'd1,
    ST_MISS = 2'd2
  } state_t;

  state_t          state_reg;
  state_t          ret_reg;
  state_t          eff_state;
  logic [CW-1:0]   lu_cnt_reg;
  logic            upd_done_reg;

  logic [NUM_RS-1:0] rs_hit_mem;
  logic              lu_hit;
  logic              lu_stall;
  logic              stall_ex;
  logic              br_mispred;
  logic              br_redir;
  logic              upd_fire;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_RS; gi++) begin : g_fwd
      logic [4:0]    rs_addr;
      logic [SW-1:0] sel;

      assign rs_addr = rs_addr_ex_i[gi*5 +: 5];

      // Walk from farthest to nearest so the lowest-index (youngest) producer wins.
      always_comb begin
        sel = '0;
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
          if (wb_we_i[k] && rs_used_ex_i[gi] && (rs_addr != 5'd0) &&
              (wb_addr_i[k*5 +: 5] == rs_addr)) begin
            sel = SW'(k + 1);
          end
        end
      end

      assign rs_hit_mem[gi] = rs_used_ex_i[gi] && wb_we_i[0] && (rs_addr != 5'd0) &&
                              (wb_addr_i[4:0] == rs_addr);
      assign fwd_sel_o[gi*SW +: SW] = rst ? '0 : sel;
    end
  endgenerate

  // Leaving MISS happens in the same cycle the miss drops, so decode as the return state.
  assign eff_state  = (state_reg == ST_MISS) ? ret_reg : state_reg;
  assign lu_hit     = mem_load_i && (|rs_hit_mem);
  assign lu_stall   = !mem_miss_i && ((eff_state == ST_LU) || ((eff_state == ST_RUN) && lu_hit));
  assign stall_ex   = mem_miss_i || lu_stall;
  assign br_mispred = USE_BP ? (branch_taken_i ^ branch_pred_i) : branch_taken_i;
  assign br_redir   = branch_in_ex_i && br_mispred;
  assign upd_fire   = USE_BP && branch_in_ex_i && !upd_done_reg && (branch_taken_i ^ branch_pred_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_RUN;
      ret_reg      <= ST_RUN;
      lu_cnt_reg   <= '0;
      upd_done_reg <= 1'b0;
    end else begin
      if (mem_miss_i) begin
        state_reg <= ST_MISS;
        if (state_reg != ST_MISS) ret_reg <= state_reg;
      end else begin
        case (eff_state)
          ST_LU: begin
            lu_cnt_reg <= lu_cnt_reg - CW'(1);
            state_reg  <= (lu_cnt_reg == CW'(1)) ? ST_RUN : ST_LU;
          end
          default: begin
            if (lu_hit && (LU_CYCLES > 1)) begin
              state_reg  <= ST_LU;
              lu_cnt_reg <= LU_INIT;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        endcase
      end
      // Remember an update issued under a frozen EX so the held branch does not re-fire.
      if (!stall_ex) upd_done_reg <= 1'b0;
      else if (upd_fire) upd_done_reg <= 1'b1;
    end
  end

  always_comb begin
    stall_o     = 5'b00000;
    clear_o     = 5'b00000;
    pc_set_o    = 1'b0;
    pc_mux_o    = PC_BOOT;
    btb_we_o    = 1'b0;
    btb_clear_o = 1'b0;
    bht_we_o    = 1'b0;
    if (!rst) begin
      if (mem_miss_i) begin
        stall_o = 5'b11111;
      end else if (lu_stall) begin
        stall_o = 5'b00111;
        clear_o = 5'b01000;
      end else if (br_redir) begin
        pc_set_o = 1'b1;
        pc_mux_o = branch_taken_i ? PC_BRANCH : PC_EX_INCR;
        clear_o  = 5'b00110;
      end else if (jump_i) begin
        pc_set_o = 1'b1;
        pc_mux_o = PC_JUMP;
        clear_o  = 5'b00010;
      end
      if (upd_fire) begin
        btb_we_o    = branch_taken_i;
        btb_clear_o = !branch_taken_i;
        bht_we_o    = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] lu_stall_cnt_reg;
  logic [31:0] miss_stall_cnt_reg;
  logic [31:0] mispredict_cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      lu_stall_cnt_reg   <= '0;
      miss_stall_cnt_reg <= '0;
      mispredict_cnt_reg <= '0;
    end else begin
      if (lu_stall) lu_stall_cnt_reg <= lu_stall_cnt_reg + 32'd1;
      if (mem_miss_i) miss_stall_cnt_reg <= miss_stall_cnt_reg + 32'd1;
      if (br_redir && !stall_ex) mispredict_cnt_reg <= mispredict_cnt_reg + 32'd1;
    end
  end

  assign perf_cnt_o = rst ? 96'd0 : {mispredict_cnt_reg, miss_stall_cnt_reg, lu_stall_cnt_reg};
`endif

endmodule
